// File: rtl/tff_counter.sv
// -----------------------------------------------------------------------------
// tff_counter
// Up/down modulo counter built from a bank of WIDTH toggle-flip-flop cells.
// The next value is computed arithmetically. Each bit then toggles when its
// T term (q ^ next) is 1, so q always matches a plain binary counter.
//
// Parameters
//   WIDTH     counter width in bits (1..32)
//   MODULUS   count range 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE  0 = wrap at the ends, 1 = hold at the ends
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   en        count enable
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load of load_val (clamped to MODULUS-1)
//   load_val  value to load
//   clear     synchronous clear to 0 (highest priority)
//   q         registered count
//   qb        ~q
//   tc        next enabled edge wraps or saturates
//   wrap      one-cycle registered pulse after a wrap/saturation hit
// -----------------------------------------------------------------------------
module tff_counter #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  // MODULUS is 64-bit so that 2^32 is representable when WIDTH is 32.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tff_counter: WIDTH must be in 1..32");
  end else if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("tff_counter: MODULUS must be in 2..2^WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      // Comparing against MAX_VAL is equivalent to load_val >= MODULUS.
      q_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          wrap_d = 1'b1;
          q_d    = (SATURATE != 0) ? q_q : '0;
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (at_zero) begin
          wrap_d = 1'b1;
          q_d    = (SATURATE != 0) ? q_q : MAX_VAL;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  // Per-bit toggle terms feeding the T cells.
  assign t = q_q ^ q_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        q_q[i] <= t[i] ? ~q_q[i] : q_q[i];
      end
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign qb   = ~q_q;
  assign wrap = wrap_q;
  // tc is gated by en only; clear and load do not suppress it.
  assign tc   = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter. There are two 4-bit, modulus-10 instances,
// one that wraps and one that saturates. Both are driven by the same inputs.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, load, clear;
  logic [3:0] load_val;
  logic [3:0] q, qb, qs, qbs;
  logic       tc, wrap, tcs, wraps;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clear(clear),
    .q(q), .qb(qb), .tc(tc), .wrap(wrap)
  );

  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clear(clear),
    .q(qs), .qb(qbs), .tc(tcs), .wrap(wraps)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks q, qb and wrap of the wrapping instance.
  task automatic chk_q(input string tag, input logic [3:0] exp_q, input logic exp_wrap);
    logic [3:0] exp_qb;
    exp_qb = ~exp_q;
    check({tag, ".q"}, 32'(q), 32'(exp_q));
    check({tag, ".qb"}, 32'(qb), 32'(exp_qb));
    check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  // One rising edge. Inputs change at the falling edge and outputs are
  // sampled there as well.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; clear = 1'b0; load_val = 4'd0;
    #12;
    chk_q("rst_init", 4'd0, 1'b0);
    check("rst_init.sat_q", 32'(qs), 32'd0);

    // Load 5, then assert reset asynchronously between edges.
    @(negedge clk);
    reset = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    chk_q("load5", 4'd5, 1'b0);
    #2 reset = 1'b0;
    #1 chk_q("async_rst", 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk_q("rst_release", 4'd1, 1'b0);

    // Wrap up. The saturating instance follows the same path up to 9.
    clear = 1'b1;
    tick();
    chk_q("clear", 4'd0, 1'b0);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_q($sformatf("up%0d", i), 4'(i), 1'b0);
      check($sformatf("up%0d.tc", i), 32'(tc), (i == 9) ? 32'd1 : 32'd0);
      check($sformatf("up%0d.sat_q", i), 32'(qs), 32'(i));
      tick();
    end
    chk_q("wrap_up", 4'd0, 1'b1);
    check("sat_hit1.q", 32'(qs), 32'd9);
    check("sat_hit1.wrap", 32'(wraps), 32'd1);
    check("sat_hit1.tc", 32'(tcs), 32'd1);
    tick();
    chk_q("after_wrap", 4'd1, 1'b0);
    check("sat_hit2.q", 32'(qs), 32'd9);
    check("sat_hit2.wrap", 32'(wraps), 32'd1);
    check("sat_hit2.qb", 32'(qbs), 32'h6);
    tick();
    check("sat_hit3.q", 32'(qs), 32'd9);
    check("sat_hit3.wrap", 32'(wraps), 32'd1);
    check("sat_hit3.tc", 32'(tcs), 32'd1);

    // Wrap down. Load takes priority over en.
    load = 1'b1; load_val = 4'd0; up = 1'b0;
    tick();
    chk_q("load0", 4'd0, 1'b0);
    load = 1'b0;
    #1 check("down.tc", 32'(tc), 32'd1);
    tick();
    chk_q("wrap_down", 4'd9, 1'b1);
    check("sat_down.q", 32'(qs), 32'd0);
    check("sat_down.wrap", 32'(wraps), 32'd1);
    tick();
    chk_q("down8", 4'd8, 1'b0);
    tick();
    chk_q("down7", 4'd7, 1'b0);

    // Priority and clamp.
    clear = 1'b1; load = 1'b1; load_val = 4'd7; up = 1'b1;
    tick();
    chk_q("clr_over_load", 4'd0, 1'b0);
    clear = 1'b0; load_val = 4'd13;
    tick();
    chk_q("clamp13", 4'd9, 1'b0);
    load_val = 4'd3;
    #1 check("tc_ignores_load", 32'(tc), 32'd1);
    tick();
    chk_q("load_over_en", 4'd3, 1'b0);
    load_val = 4'd9;
    tick();
    chk_q("load9", 4'd9, 1'b0);

    // Hold, then switch direction on every edge.
    load_val = 4'd6;
    tick();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_q($sformatf("hold%0d", i), 4'd6, 1'b0);
      check($sformatf("hold%0d.tc", i), 32'(tc), 32'd0);
    end
    en = 1'b1; up = 1'b1;
    tick();
    chk_q("dir0", 4'd7, 1'b0);
    up = 1'b0;
    tick();
    chk_q("dir1", 4'd6, 1'b0);
    up = 1'b1;
    tick();
    chk_q("dir2", 4'd7, 1'b0);
    up = 1'b0;
    tick();
    chk_q("dir3", 4'd6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
